// File: rtl/lmdpl_pkg.sv
// Shared types and default timing constants for the LMDPL phase controller.
// Phase decode helper keeps the encoder and the FSM in agreement about when rails may carry data.
package lmdpl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      EVAL,
      SAMP,
      DONE
   } state_t;

   typedef enum logic {
      PHASE_ZERO,
      PHASE_EVAL
   } phase_t;

   localparam int PRE_CYCLES_DEF  = 1;
   localparam int EVAL_CYCLES_DEF = 2;
   localparam int ROUNDS_DEF      = 10;

   // Only EVAL and SAMP may expose the evaluate pattern on the rails.
   function automatic phase_t phase_of(input state_t s);
      return (s == EVAL || s == SAMP) ? PHASE_EVAL : PHASE_ZERO;
   endfunction

endpackage

// File: rtl/lmdpl_phase_ctrl_if.sv
// Operand, mask and dual-rail bundle between the phase controller and its environment.
interface lmdpl_phase_ctrl_if #(parameter int W = 8);

   logic         start;
   logic [W-1:0] data_in;
   logic [W-1:0] mask_in;
   logic [W-1:0] res_t;
   logic [W-1:0] res_f;
   logic [W-1:0] rail_t;
   logic [W-1:0] rail_f;
   logic [W-1:0] mask_q;
   logic [W-1:0] result;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      output start, data_in, mask_in, res_t, res_f,
      input  rail_t, rail_f, mask_q, result, busy, done, err
   );

   modport slave (
      input  start, data_in, mask_in, res_t, res_f,
      output rail_t, rail_f, mask_q, result, busy, done, err
   );

endinterface

// File: rtl/lmdpl_rail_encoder.sv
// Combinational masked dual-rail encoder: all-zero rails outside evaluation,
// complementary masked pair during evaluation.
module lmdpl_rail_encoder
   import lmdpl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] data,
   input  logic [W-1:0] mask,
   input  phase_t       phase,
   output logic [W-1:0] rail_t,
   output logic [W-1:0] rail_f
);

   always_comb begin
      rail_t = '0;
      rail_f = '0;
      if (phase == PHASE_EVAL) begin
         rail_t = data ^ mask;
         rail_f = ~(data ^ mask);
      end
   end

endmodule

// File: rtl/lmdpl_phase_ctrl.sv
// Precharge/evaluate/sample sequencer for a masked dual-rail gate network.
// Rails are decoded from the registered state so a reset zeroes them on the very next cycle.
module lmdpl_phase_ctrl
   import lmdpl_pkg::*;
#(
   parameter int W           = 8,
   parameter int PRE_CYCLES  = PRE_CYCLES_DEF,
   parameter int EVAL_CYCLES = EVAL_CYCLES_DEF,
   parameter int ROUNDS      = ROUNDS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   lmdpl_phase_ctrl_if.slave   bus
);

   localparam logic [3:0] PRE_LAST   = 4'(PRE_CYCLES - 1);
   localparam logic [3:0] EVAL_LAST  = 4'(EVAL_CYCLES - 1);
   localparam logic [3:0] ROUND_LAST = 4'(ROUNDS - 1);

   state_t       state;
   logic [3:0]   phase_cnt;
   logic [3:0]   round_cnt;
   logic [W-1:0] data_q;
   logic [W-1:0] mask_r;
   logic [W-1:0] result_r;
   logic         busy_r;
   logic         done_r;
   logic         err_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase_cnt <= '0;
         round_cnt <= '0;
         data_q    <= '0;
         mask_r    <= '0;
         result_r  <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  data_q    <= bus.data_in;
                  mask_r    <= bus.mask_in;
                  round_cnt <= '0;
                  phase_cnt <= '0;
                  err_r     <= 1'b0;
                  busy_r    <= 1'b1;
                  state     <= PRE;
               end
            end
            PRE: begin
               if (phase_cnt == PRE_LAST) begin
                  phase_cnt <= '0;
                  state     <= EVAL;
               end else begin
                  phase_cnt <= phase_cnt + 4'd1;
               end
            end
            EVAL: begin
               if (phase_cnt == EVAL_LAST) begin
                  phase_cnt <= '0;
                  state     <= SAMP;
               end else begin
                  phase_cnt <= phase_cnt + 4'd1;
               end
            end
            SAMP: begin
               result_r  <= bus.res_t;
               phase_cnt <= '0;
               // A pair reading 00 or 11 means the network lost its dual-rail encoding.
               if (|(~(bus.res_t ^ bus.res_f))) begin
                  err_r <= 1'b1;
               end
               if (round_cnt == ROUND_LAST) begin
                  done_r <= 1'b1;
                  state  <= DONE;
               end else begin
                  round_cnt <= round_cnt + 4'd1;
                  mask_r    <= bus.mask_in;
                  state     <= PRE;
               end
            end
            DONE: begin
               phase_cnt <= '0;
               busy_r    <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               phase_cnt <= '0;
               busy_r    <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   lmdpl_rail_encoder #(.W(W)) encoder (
      .data   (data_q),
      .mask   (mask_r),
      .phase  (phase_of(state)),
      .rail_t (bus.rail_t),
      .rail_f (bus.rail_f)
   );

   assign bus.mask_q = mask_r;
   assign bus.result = result_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.err    = err_r;

endmodule

// File: doc/lmdpl_phase_ctrl.md
LMDPL_PHASE_CTRL -- requirements
Module: lmdpl_phase_ctrl

Interface
REQ-001 Parameter W, default 8: datapath width in bits, i.e. the number of dual-rail pairs.
REQ-002 Parameter PRE_CYCLES, default 1: cycles per precharge phase; legal range 1..15.
REQ-003 Parameter EVAL_CYCLES, default 2: cycles per evaluate phase; legal range 1..15; covers settle time of the AND3/OR4 gate network.
REQ-004 Parameter ROUNDS, default 10: precharge/evaluate/sample rounds per operation; legal range 1..15.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 start  in  1  operation request; sampled in IDLE only.
REQ-008 data_in  in  W  unmasked operand.
REQ-009 mask_in  in  W  fresh random mask.
REQ-010 res_t / res_f  in  W each  true/false rails returned from the gate network.
REQ-011 rail_t / rail_f  out  W each  masked dual-rail drive into the gate network.
REQ-012 mask_q  out  W  mask currently applied.
REQ-013 result  out  W  captured masked result.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 err  out  1  sticky encoding-error flag.

Function
REQ-017 States SHALL be IDLE, PRE, EVAL, SAMP and DONE.
REQ-018 IDLE with start=1 SHALL latch mask_q<=mask_in and data<=data_in, clear the round counter and err, and go to PRE.
REQ-019 PRE SHALL drive rail_t=rail_f=0 for exactly PRE_CYCLES cycles, then go to EVAL.
REQ-020 EVAL SHALL drive rail_t=data^mask_q and rail_f=~(data^mask_q) for exactly EVAL_CYCLES cycles, then go to SAMP.
REQ-021 SAMP SHALL last 1 cycle with rails still in evaluate values, capture result<=res_t, and set err if any bit has res_t==res_f (00 or 11).
REQ-022 On leaving SAMP: if the round counter equals ROUNDS-1, go to DONE; otherwise increment the counter, reload mask_q<=mask_in, and go to PRE.
REQ-023 DONE SHALL last 1 cycle with done=1 and rails 0, then go to IDLE.
REQ-024 Latency: done SHALL be high exactly ROUNDS*(PRE_CYCLES+EVAL_CYCLES+1)+1 cycles after the edge that sampled start; 41 cycles with the defaults.
REQ-025 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-026 Rails SHALL never be driven to the evaluate pattern outside EVAL and SAMP, so every evaluation is preceded by at least PRE_CYCLES all-zero cycles.
REQ-027 The phase cycle counter SHALL be 4 bits and reset to 0 on every state change.
REQ-028 result and err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state=IDLE, all counters=0, and rail_t=rail_f=mask_q=result=0, with busy=done=err=0.
REQ-030 Reset asserted mid-operation SHALL abort with no done pulse; rails SHALL be 0 in the first cycle after the reset edge.

Structure
REQ-031 Package lmdpl_pkg SHALL hold the state enum and the default constants for PRE_CYCLES, EVAL_CYCLES and ROUNDS.
REQ-032 Sub-module lmdpl_rail_encoder SHALL be used: inputs data, mask and phase; outputs rail_t and rail_f; purely combinational.
REQ-033 The FSM and counters SHALL remain in lmdpl_phase_ctrl.

Verification
REQ-034 Default parameters, data_in=8'hA5, mask_in=8'h3C, loopback res=rails: rail_t=8'h99 and rail_f=8'h66 in EVAL, result=8'h99, err=0, done high 41 cycles after start.
REQ-035 mask_in changed to 8'hFF after round 0: round-1 EVAL shows rail_t=8'h5A, and the zero-rail PRE cycle precedes it.
REQ-036 res_t=res_f=8'h01 forced during one SAMP: err=1, and err stays 1 through DONE and IDLE until the next start.
REQ-037 start pulsed in cycles 5 and 41 of an operation: neither pulse is accepted, and busy falls after the single done.
REQ-038 rst_n=0 during round 3 EVAL: next cycle state=IDLE, rails=0, busy=0, and no done pulse.
REQ-039 PRE_CYCLES=2, EVAL_CYCLES=3, ROUNDS=1: done 7 cycles after start, with a precharge of exactly 2 cycles.
